// File: rtl/leitor_dht11.sv
// DHT11 single-wire reader: issues the host start pulse, times the sensor's
// response and data pulses, and publishes a checksum-verified 40-bit frame.
module leitor_dht11 #(
    parameter int T_START   = 18000,
    parameter int T_LIMIAR  = 40,
    parameter int T_TIMEOUT = 255
) (
    input  logic        clock_1MHZ,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic [39:0] dados,
    output logic        ocupado,
    output logic        pronto,
    output logic        erro
);
    typedef enum logic [2:0] {
        OCIOSO, START_BAIXO, ESPERA_RESP, RESP_BAIXO,
        RESP_ALTO, BIT_BAIXO, BIT_ALTO, VERIFICA
    } estado_t;

    estado_t     estado;
    logic        sync1, sync2, linha_ant;
    logic [15:0] fase;
    logic [5:0]  nbits;
    logic [39:0] shift;
    logic        subida, descida, evento, esgotou, bit_lido;
    logic [7:0]  soma;

    // Idle line is high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clock_1MHZ) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            linha_ant <= 1'b1;
        end else begin
            sync1     <= dht_in;
            sync2     <= sync1;
            linha_ant <= sync2;
        end
    end

    assign subida   = sync2 & ~linha_ant;
    assign descida  = ~sync2 & linha_ant;
    assign esgotou  = (fase >= 16'(T_TIMEOUT - 1));
    assign bit_lido = (fase > 16'(T_LIMIAR));
    assign soma     = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];

    always_comb begin
        evento = 1'b0;
        case (estado)
            ESPERA_RESP, RESP_ALTO, BIT_ALTO: evento = descida;
            RESP_BAIXO, BIT_BAIXO:            evento = subida;
            default:                          evento = 1'b0;
        endcase
    end

    always_ff @(posedge clock_1MHZ) begin
        if (reset) begin
            estado  <= OCIOSO;
            dht_oe  <= 1'b0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
            dados   <= '0;
            fase    <= '0;
            nbits   <= '0;
            shift   <= '0;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            fase   <= (fase == '1) ? fase : fase + 16'd1;
            case (estado)
                // ocupado is still high in the pronto/erro cycle, which also
                // keeps a request arriving in that cycle from being accepted.
                OCIOSO: begin
                    ocupado <= 1'b0;
                    if (iniciar && !ocupado) begin
                        estado  <= START_BAIXO;
                        dht_oe  <= 1'b1;
                        ocupado <= 1'b1;
                        fase    <= '0;
                        nbits   <= '0;
                    end
                end
                START_BAIXO: begin
                    if (fase == 16'(T_START - 1)) begin
                        estado <= ESPERA_RESP;
                        dht_oe <= 1'b0;
                        fase   <= '0;
                    end
                end
                ESPERA_RESP, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO: begin
                    if (evento) begin
                        fase <= '0;
                        case (estado)
                            ESPERA_RESP: estado <= RESP_BAIXO;
                            RESP_BAIXO:  estado <= RESP_ALTO;
                            RESP_ALTO:   estado <= BIT_BAIXO;
                            BIT_BAIXO:   estado <= BIT_ALTO;
                            default: begin
                                shift  <= {shift[38:0], bit_lido};
                                nbits  <= nbits + 6'd1;
                                estado <= (nbits == 6'd39) ? VERIFICA : BIT_BAIXO;
                            end
                        endcase
                    end else if (esgotou) begin
                        estado <= OCIOSO;
                        fase   <= '0;
                        erro   <= 1'b1;
                    end
                end
                VERIFICA: begin
                    estado <= OCIOSO;
                    fase   <= '0;
                    if (soma == shift[7:0]) begin
                        dados  <= shift;
                        pronto <= 1'b1;
                    end else begin
                        erro <= 1'b1;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_leitor_dht11.sv
// Bench for leitor_dht11: an open-drain sensor model plays frames back and a
// frame-level model predicts pronto/erro and the published data.
module tb_leitor_dht11;
    localparam int TS    = 500;
    localparam int TLIM  = 40;
    localparam int TO    = 255;
    localparam int NRAND = 5;

    typedef struct {
        logic [39:0] frame;
        bit          poke;
        int          rst_bit;
        bit          fixed_t;
        bit          exp_ok;
    } vec_t;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        iniciar    = 1'b0;
    logic        sensor_low = 1'b0;
    logic        dht_in, dht_oe, ocupado, pronto, erro;
    logic [39:0] dados;
    logic [39:0] dados_exp  = '0;
    int          checks     = 0;
    int          errors     = 0;
    int          pronto_cnt = 0;
    int          erro_cnt   = 0;

    // Line is pulled high unless the host pad or the sensor pulls it low.
    assign dht_in = ~(dht_oe | sensor_low);

    leitor_dht11 #(.T_START(TS), .T_LIMIAR(TLIM), .T_TIMEOUT(TO)) dut (
        .clock_1MHZ (clk),
        .reset      (reset),
        .iniciar    (iniciar),
        .dht_in     (dht_in),
        .dht_oe     (dht_oe),
        .dados      (dados),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] csum(input logic [39:0] f);
        int s = 0;
        for (int b = 1; b < 5; b++) s += int'(f[8*b +: 8]);
        return 8'(s % 256);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (pronto) pronto_cnt++;
            if (erro) erro_cnt++;
            if (pronto || erro) chk("pulse_exclusive", 64'(pronto & erro), 64'd0);
            if (dht_oe) chk("oe_implies_busy", 64'(ocupado), 64'd1);
        end
    end

    task automatic hold(input logic low, input int n);
        sensor_low = low;
        repeat (n) @(negedge clk);
    endtask

    // Pulse iniciar and measure how long the pad holds the line low.
    task automatic start_read(input bit poke);
        int n = 0;
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        while (dht_oe && n < TS + 20) begin
            n++;
            iniciar = poke && (n == 10);
            @(negedge clk);
        end
        iniciar = 1'b0;
        chk("oe_len", 64'(n), 64'(TS));
    endtask

    task automatic do_read(input logic [39:0] f, input bit poke, input int rst_bit,
                           input bit fixed_t, input bit exp_ok);
        int p0, e0, n, h;
        p0 = pronto_cnt;
        e0 = erro_cnt;
        start_read(poke);
        hold(1'b0, 30);
        hold(1'b1, 80);
        hold(1'b0, 80);
        for (int i = 39; i >= 0; i--) begin
            hold(1'b1, 50);
            // Counter at the falling edge is high-time minus one, so 42 us is the shortest '1'.
            if (fixed_t)         h = f[i] ? 70 : 27;
            else if (i % 5 == 0) h = f[i] ? TLIM + 2 : TLIM + 1;
            else                 h = f[i] ? int'($urandom_range(80, 42)) : int'($urandom_range(41, 15));
            if (39 - i == rst_bit) begin
                hold(1'b0, 6);
                reset = 1'b1;
                @(negedge clk);
                chk("rst_oe", 64'(dht_oe), 64'd0);
                chk("rst_busy", 64'(ocupado), 64'd0);
                chk("rst_pronto", 64'(pronto), 64'd0);
                chk("rst_erro", 64'(erro), 64'd0);
                chk("rst_dados", 64'(dados), 64'd0);
                reset = 1'b0;
                dados_exp = '0;
                hold(1'b0, 200);
                chk("rst_no_pulse", 64'(pronto_cnt - p0 + erro_cnt - e0), 64'd0);
                chk("rst_idle", 64'(ocupado), 64'd0);
                return;
            end
            if (poke && i == 34) begin
                hold(1'b0, 10);
                iniciar = 1'b1;
                @(negedge clk);
                iniciar = 1'b0;
                hold(1'b0, h - 11);
            end else begin
                hold(1'b0, h);
            end
        end
        sensor_low = 1'b1;
        n = 0;
        while (!(pronto || erro) && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("exit_pulse", 64'(pronto || erro), 64'd1);
        chk("exit_busy", 64'(ocupado), 64'd1);
        @(negedge clk);
        chk("exit_idle", 64'(ocupado), 64'd0);
        hold(1'b0, 30);
        chk("no_requeue", 64'(dht_oe | ocupado), 64'd0);
        chk("pronto_pulses", 64'(pronto_cnt - p0), 64'(exp_ok));
        chk("erro_pulses", 64'(erro_cnt - e0), 64'(!exp_ok));
        if (exp_ok) dados_exp = f;
        chk("dados", 64'(dados), 64'(dados_exp));
    endtask

    task automatic no_response();
        int n = 0;
        int e0 = erro_cnt;
        start_read(1'b0);
        while (!erro && n < TO + 50) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", 64'(n), 64'(TO));
        chk("timeout_pronto", 64'(pronto), 64'd0);
        chk("timeout_busy", 64'(ocupado), 64'd1);
        @(negedge clk);
        chk("timeout_idle", 64'(ocupado), 64'd0);
        chk("timeout_erro_pulses", 64'(erro_cnt - e0), 64'd1);
        chk("timeout_dados", 64'(dados), 64'(dados_exp));
    endtask

    initial begin
        vec_t        tbl[7];
        logic [39:0] f;
        tbl[0] = '{40'h350018004D, 1'b0, -1, 1'b1, 1'b1};
        tbl[1] = '{40'h350018004E, 1'b0, -1, 1'b1, 1'b0};
        tbl[2] = '{40'h3C051A025D, 1'b1, -1, 1'b0, 1'b1};
        tbl[3] = '{40'h350018004D, 1'b0, 20, 1'b0, 1'b0};
        tbl[4] = '{40'h350018004D, 1'b0, -1, 1'b0, 1'b1};
        tbl[5] = '{40'hFFFFFFFFFC, 1'b0, -1, 1'b0, 1'b1};
        tbl[6] = '{40'h0000000000, 1'b0, -1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_oe", 64'(dht_oe), 64'd0);
        chk("reset_busy", 64'(ocupado), 64'd0);
        chk("reset_pronto", 64'(pronto), 64'd0);
        chk("reset_erro", 64'(erro), 64'd0);
        chk("reset_dados", 64'(dados), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++)
            do_read(tbl[k].frame, tbl[k].poke, tbl[k].rst_bit, tbl[k].fixed_t, tbl[k].exp_ok);

        no_response();

        for (int k = 0; k < NRAND; k++) begin
            f[39:8] = $urandom();
            f[7:0]  = (k % 2 == 0) ? csum(f) : 8'($urandom_range(255, 0));
            do_read(f, 1'b0, -1, 1'b0, csum(f) == f[7:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/leitor_dht11.md
LEITOR_DHT11 -- requirements
Module: leitor_dht11

Interface
REQ-001 Parameter T_START, 18000, cycles dht_oe is held at 1 for the host start pulse (18 ms at 1 MHz).
REQ-002 Parameter T_LIMIAR, 40, high-phase cycle count above which a data bit is decoded as 1.
REQ-003 Parameter T_TIMEOUT, 255, maximum cycles allowed in any wait state before abort.
REQ-004 clock_1MHZ  input  1  sole clock: the 1 MHz output of the clock divider stage; 1 cycle = 1 us.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 iniciar  input  1  request one sensor read; sampled only in OCIOSO.
REQ-007 dht_in  input  1  raw (asynchronous) level of the DHT11 data line.
REQ-008 dht_oe  output  1  1 = pad drives the line low; 0 = line released (pulled high externally).
REQ-009 dados  output  40  last valid frame {umid_int, umid_dec, temp_int, temp_dec, checksum}.
REQ-010 ocupado  output  1  high from the cycle after iniciar is accepted until return to OCIOSO.
REQ-011 pronto  output  1  one-cycle pulse: new valid frame loaded into dados.
REQ-012 erro  output  1  one-cycle pulse: read aborted (timeout or checksum mismatch).

Function
REQ-013 dht_in SHALL pass through a two-flop synchronizer; all edge detection SHALL use the synchronized level versus its one-cycle-delayed copy.
REQ-014 FSM states SHALL be OCIOSO, START_BAIXO, ESPERA_RESP, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO, VERIFICA.
REQ-015 OCIOSO: iniciar=1 -> START_BAIXO next cycle; phase counter cleared; bit counter cleared.
REQ-016 START_BAIXO: dht_oe=1 for exactly T_START cycles, then dht_oe=0 and -> ESPERA_RESP.
REQ-017 ESPERA_RESP: falling edge -> RESP_BAIXO; RESP_BAIXO: rising edge -> RESP_ALTO; RESP_ALTO: falling edge -> BIT_BAIXO.
REQ-018 BIT_BAIXO: rising edge -> BIT_ALTO with phase counter cleared to 0.
REQ-019 BIT_ALTO: on falling edge, bit = 1 if phase counter > T_LIMIAR else 0; bit shifted into a 40-bit shift register, MSB first (first received bit ends in bit 39).
REQ-020 After the 40th bit -> VERIFICA; otherwise -> BIT_BAIXO.
REQ-021 VERIFICA (one cycle): if (sum of bytes [39:32],[31:24],[23:16],[15:8]) mod 256 equals [7:0], load dados and pulse pronto; else pulse erro and leave dados unchanged; then -> OCIOSO.
REQ-022 Phase counter: 16 bits, reset on every state change, saturating at all-ones, never wraps.
REQ-023 In ESPERA_RESP, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO: phase counter reaching T_TIMEOUT SHALL pulse erro and go to OCIOSO; dados unchanged.
REQ-024 Bit counter: 6 bits, counts 0..40, cleared on every entry to START_BAIXO.
REQ-025 iniciar asserted while ocupado=1 SHALL be ignored, not queued.
REQ-026 pronto and erro SHALL never be high in the same cycle; both SHALL be 0 outside the exit cycle.
REQ-027 dht_oe SHALL be 1 only in START_BAIXO.
REQ-028 ocupado SHALL be 1 in every state except OCIOSO, including the pronto/erro cycle.

Reset
REQ-029 reset=1 at a clock edge SHALL force, from the next cycle: state OCIOSO, dht_oe=0, ocupado=0, pronto=0, erro=0, dados=40'h0, both counters and shift register 0.
REQ-030 Reset mid-operation SHALL abort without pronto or erro pulses; the line SHALL be released the cycle after.
REQ-031 Synchronizer flops SHALL reset to 1 (idle line level) to avoid a false edge on exit from reset.

Verification
REQ-032 Reset: hold reset 3 cycles -> dht_oe=0, ocupado=0, pronto=0, erro=0, dados=0.
REQ-033 Valid frame: iniciar, sensor model sends 35 00 18 00 4D (80/80 us response, 50 us low, 27 us high = 0, 70 us high = 1) -> dht_oe high exactly 18000 cycles, dados=40'h350018004D, single pronto pulse, erro=0.
REQ-034 Bad checksum: same frame with last byte 4E -> one erro pulse, pronto=0, dados retains previous value.
REQ-035 No response: line left high after start -> erro pulse exactly T_TIMEOUT=255 cycles after entering ESPERA_RESP, ocupado falls with it.
REQ-036 Reset during bit 20 -> next cycle OCIOSO, dht_oe=0, no pulses; subsequent iniciar completes a valid read.
REQ-037 iniciar pulsed during START_BAIXO and BIT_ALTO -> ignored; exactly one read, one pronto pulse.
